// File: rtl/pipe_mips32_fwd_if.sv
// Harness-side bus of the core: program-load port into instruction memory and debug register read.
interface pipe_mips32_fwd_if #(
  parameter int IMEM_DEPTH = 1024
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [4:0]    dbg_addr;
  logic [31:0]   dbg_data;

  modport master (output prog_we, prog_addr, prog_data, dbg_addr, input dbg_data);
  modport slave  (input prog_we, prog_addr, prog_data, dbg_addr, output dbg_data);
endinterface

// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32 core with forwarding, load-use interlock, branch flush and halt/trap.
// IMEM_DEPTH and DMEM_DEPTH are powers of two so address wrap is plain truncation.
module pipe_mips32_fwd #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             run,
  pipe_mips32_fwd_if.slave bus,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_ADD   = 6'b000000, OP_SUB   = 6'b000001, OP_AND  = 6'b000010,
                         OP_OR    = 6'b000011, OP_SLT   = 6'b000100, OP_MUL  = 6'b000101,
                         OP_ADDI  = 6'b001010, OP_SUBI  = 6'b001011, OP_SLTI = 6'b001100,
                         OP_LW    = 6'b001000, OP_SW    = 6'b001001, OP_BNEQZ = 6'b001101,
                         OP_BEQZ  = 6'b001110, OP_HLT   = 6'b111111;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
    logic       wr;
    logic [4:0] dst;
    logic       use_rs;
    logic       use_rt;
    logic       ld;
    logic       st;
    logic       br;
    logic       bz;
    logic       stop;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic           valid;
    logic [31:0]    ir;
    logic [IAW-1:0] npc;
  } ifid_t;

  typedef struct packed {
    ctl_t           ctl;
    logic [IAW-1:0] npc;
    logic [4:0]     rs;
    logic [4:0]     rt;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    imm;
  } idex_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] alu;
    logic [31:0] b;
  } exmem_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] alu;
    logic [31:0] lmd;
  } memwb_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  logic [IAW-1:0]   pc_q, pc_d;
  ifid_t            ifid_q, ifid_d;
  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic           adv, rf_we, stall, fetch_freeze, ex_take;
  logic           src_hit_ex, src_hit_mem;
  ctl_t           id_ctl;
  logic [4:0]     id_rs, id_rt;
  logic [31:0]    wb_data, id_a, id_b, ex_a, ex_b, ex_alu;
  logic [IAW-1:0] ex_target;

  function automatic ctl_t decode(input logic [31:0] ir);
    ctl_t c;
    c    = '0;
    c.op = ir[31:26];
    case (ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        c.wr = 1'b1; c.dst = ir[15:11]; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_SLTI: begin
        c.wr = 1'b1; c.dst = ir[20:16]; c.use_rs = 1'b1;
      end
      OP_LW:    begin c.wr = 1'b1; c.dst = ir[20:16]; c.use_rs = 1'b1; c.ld = 1'b1; end
      OP_SW:    begin c.use_rs = 1'b1; c.use_rt = 1'b1; c.st = 1'b1; end
      OP_BNEQZ: begin c.use_rs = 1'b1; c.br = 1'b1; end
      OP_BEQZ:  begin c.use_rs = 1'b1; c.br = 1'b1; c.bz = 1'b1; end
      OP_HLT:   c.stop = 1'b1;
      default:  begin c.stop = 1'b1; c.ill = 1'b1; end
    endcase
    return c;
  endfunction

  function automatic logic hits(input ctl_t p, input logic [4:0] r);
    return p.valid && p.wr && (p.dst == r) && (r != 5'd0);
  endfunction

  // Decode, write-before-read register fetch and hazard detection for the ID stage.
  always_comb begin
    adv     = run && !halted_q;
    wb_data = memwb_q.ctl.ld ? memwb_q.lmd : memwb_q.alu;
    rf_we   = adv && hits(memwb_q.ctl, memwb_q.ctl.dst);

    id_rs        = ifid_q.ir[25:21];
    id_rt        = ifid_q.ir[20:16];
    id_ctl       = decode(ifid_q.ir);
    id_ctl.valid = ifid_q.valid;
    id_a = (id_rs == 5'd0) ? 32'd0 : (rf_we && memwb_q.ctl.dst == id_rs) ? wb_data : rf[id_rs];
    id_b = (id_rt == 5'd0) ? 32'd0 : (rf_we && memwb_q.ctl.dst == id_rt) ? wb_data : rf[id_rt];

    src_hit_ex  = (id_ctl.use_rs && hits(idex_q.ctl, id_rs)) ||
                  (id_ctl.use_rt && hits(idex_q.ctl, id_rt));
    src_hit_mem = (id_ctl.use_rs && hits(exmem_q.ctl, id_rs)) ||
                  (id_ctl.use_rt && hits(exmem_q.ctl, id_rt));
    if (FORWARD_EN) stall = id_ctl.valid && idex_q.ctl.ld && src_hit_ex;
    else            stall = id_ctl.valid && (src_hit_ex || src_hit_mem);

    fetch_freeze = (id_ctl.valid && id_ctl.stop) || (idex_q.ctl.valid && idex_q.ctl.stop) ||
                   (exmem_q.ctl.valid && exmem_q.ctl.stop) || (memwb_q.ctl.valid && memwb_q.ctl.stop);
  end

  // EX stage: youngest producer wins the bypass, then ALU and branch resolution.
  always_comb begin
    ex_a = idex_q.a;
    if (FORWARD_EN && hits(exmem_q.ctl, idex_q.rs))      ex_a = exmem_q.alu;
    else if (FORWARD_EN && hits(memwb_q.ctl, idex_q.rs)) ex_a = wb_data;
    ex_b = idex_q.b;
    if (FORWARD_EN && hits(exmem_q.ctl, idex_q.rt))      ex_b = exmem_q.alu;
    else if (FORWARD_EN && hits(memwb_q.ctl, idex_q.rt)) ex_b = wb_data;

    ex_alu = 32'd0;
    case (idex_q.ctl.op)
      OP_ADD:               ex_alu = ex_a + ex_b;
      OP_SUB:               ex_alu = ex_a - ex_b;
      OP_AND:               ex_alu = ex_a & ex_b;
      OP_OR:                ex_alu = ex_a | ex_b;
      OP_SLT:               ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:               ex_alu = ex_a * ex_b;
      OP_ADDI, OP_LW, OP_SW: ex_alu = ex_a + idex_q.imm;
      OP_SUBI:              ex_alu = ex_a - idex_q.imm;
      OP_SLTI:              ex_alu = {31'd0, $signed(ex_a) < $signed(idex_q.imm)};
      default:              ex_alu = 32'd0;
    endcase

    ex_take   = idex_q.ctl.valid && idex_q.ctl.br && (idex_q.ctl.bz == (ex_a == 32'd0));
    ex_target = idex_q.npc + idex_q.imm[IAW-1:0];
  end

  // Stage advance; a taken branch overrides both the interlock and the halt fetch freeze.
  always_comb begin
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    idex_d    = idex_q;
    exmem_d   = exmem_q;
    memwb_d   = memwb_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    if (adv) begin
      exmem_d.ctl = idex_q.ctl;
      exmem_d.alu = ex_alu;
      exmem_d.b   = ex_b;
      memwb_d.ctl = exmem_q.ctl;
      memwb_d.alu = exmem_q.alu;
      memwb_d.lmd = dmem[exmem_q.alu[DAW-1:0]];
      if (memwb_q.ctl.valid) begin
        retired_d = retired_q + CNT_W'(1);
        if (memwb_q.ctl.stop) begin
          halted_d  = 1'b1;
          illegal_d = memwb_q.ctl.ill;
        end
      end
      if (ex_take) begin
        pc_d         = ex_target;
        ifid_d.valid = 1'b0;
        idex_d.ctl   = '0;
      end else if (stall) begin
        idex_d.ctl = '0;
      end else begin
        idex_d.ctl = id_ctl;
        idex_d.npc = ifid_q.npc;
        idex_d.rs  = id_rs;
        idex_d.rt  = id_rt;
        idex_d.a   = id_a;
        idex_d.b   = id_b;
        idex_d.imm = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
        if (fetch_freeze) begin
          ifid_d.valid = 1'b0;
        end else begin
          ifid_d.valid = 1'b1;
          ifid_d.ir    = imem[pc_q];
          ifid_d.npc   = pc_q + IAW'(1);
          pc_d         = pc_q + IAW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ifid_q    <= '0;
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Register file and memories keep their contents across reset.
  always_ff @(posedge clk1) begin
    if (rf_we) rf[memwb_q.ctl.dst] <= wb_data;
    if (adv && exmem_q.ctl.valid && exmem_q.ctl.st) dmem[exmem_q.alu[DAW-1:0]] <= exmem_q.b;
    if (bus.prog_we && !run) imem[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : rf[bus.dbg_addr];
  assign halted       = halted_q;
  assign illegal      = illegal_q;
  assign retired      = retired_q;
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench: one forwarding core and one interlock-only core, run on hand-assembled programs.
module tb_pipe_mips32_fwd;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_ADDI = 6'b001010, OP_LW = 6'b001000,
                         OP_SW  = 6'b001001, OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;

  logic        clk1, rst_n, run_f, run_nf;
  logic        halted_f, illegal_f, halted_nf, illegal_nf;
  logic [31:0] retired_f, retired_nf;
  logic [31:0] prog [16];
  logic [31:0] rv;
  int          checks, errors, cyc;

  pipe_mips32_fwd_if bus_f ();
  pipe_mips32_fwd_if bus_nf ();

  pipe_mips32_fwd #(.FORWARD_EN(1'b1)) dut_f (
    .clk1(clk1), .rst_n(rst_n), .run(run_f), .bus(bus_f),
    .halted(halted_f), .illegal(illegal_f), .retired(retired_f)
  );

  pipe_mips32_fwd #(.FORWARD_EN(1'b0)) dut_nf (
    .clk1(clk1), .rst_n(rst_n), .run(run_nf), .bus(bus_nf),
    .halted(halted_nf), .illegal(illegal_nf), .retired(retired_nf)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit nf, input int addr, input logic [31:0] word);
    @(negedge clk1);
    if (nf) begin
      bus_nf.prog_we = 1'b1; bus_nf.prog_addr = addr[9:0]; bus_nf.prog_data = word;
    end else begin
      bus_f.prog_we = 1'b1; bus_f.prog_addr = addr[9:0]; bus_f.prog_data = word;
    end
    @(negedge clk1);
    bus_f.prog_we  = 1'b0;
    bus_nf.prog_we = 1'b0;
  endtask

  task automatic loadProg(input bit nf, input int n);
    for (int i = 0; i < n; i++) applyStimulus(nf, i, prog[i]);
  endtask

  task automatic doReset();
    @(negedge clk1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic readReg(input bit nf, input int r, output logic [31:0] v);
    if (nf) bus_nf.dbg_addr = 5'(r);
    else    bus_f.dbg_addr  = 5'(r);
    #1;
    v = nf ? bus_nf.dbg_data : bus_f.dbg_data;
  endtask

  // Cycles are counted as rising edges with run=1 until halted is seen.
  task automatic runProgram(input bit nf, input string tag, output int cycles);
    cycles = 0;
    @(negedge clk1);
    if (nf) run_nf = 1'b1;
    else    run_f  = 1'b1;
    while (!(nf ? halted_nf : halted_f) && cycles < 200) begin
      @(negedge clk1);
      cycles++;
    end
    run_f  = 1'b0;
    run_nf = 1'b0;
    checkOutput({tag, "_halt_reached"}, 32'(nf ? halted_nf : halted_f), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; run_f = 1'b0; run_nf = 1'b0;
    bus_f.prog_we = 1'b0; bus_f.prog_addr = '0; bus_f.prog_data = '0; bus_f.dbg_addr = '0;
    bus_nf.prog_we = 1'b0; bus_nf.prog_addr = '0; bus_nf.prog_data = '0; bus_nf.dbg_addr = '0;
    repeat (2) @(negedge clk1);
    checkOutput("reset_halted", 32'(halted_f), 32'd0);
    checkOutput("reset_illegal", 32'(illegal_f), 32'd0);
    checkOutput("reset_retired", retired_f, 32'd0);
    readReg(1'b0, 0, rv);
    checkOutput("r0_reads_zero", rv, 32'd0);
    rst_n = 1'b1;

    $display("[TB] test 1: forwarding chain");
    prog[0] = ri(OP_ADDI, 1, 0, 5);
    prog[1] = ri(OP_ADDI, 2, 1, 7);
    prog[2] = rr(OP_ADD, 3, 1, 2);
    prog[3] = {OP_HLT, 26'd0};
    loadProg(1'b0, 4);
    doReset();
    runProgram(1'b0, "t1", cyc);
    checkOutput("t1_cycles", 32'(cyc), 32'd8);
    checkOutput("t1_retired", retired_f, 32'd4);
    checkOutput("t1_illegal", 32'(illegal_f), 32'd0);
    readReg(1'b0, 1, rv); checkOutput("t1_r1", rv, 32'd5);
    readReg(1'b0, 2, rv); checkOutput("t1_r2", rv, 32'd12);
    readReg(1'b0, 3, rv); checkOutput("t1_r3", rv, 32'd17);

    $display("[TB] test 4: interlock-only core on the same program");
    loadProg(1'b1, 4);
    doReset();
    runProgram(1'b1, "t4", cyc);
    checkOutput("t4_cycles", 32'(cyc), 32'd12);
    checkOutput("t4_retired", retired_nf, 32'd4);
    readReg(1'b1, 3, rv); checkOutput("t4_r3", rv, 32'd17);

    $display("[TB] test 2: store, load-use");
    prog[0] = ri(OP_ADDI, 9, 0, 42);
    prog[1] = ri(OP_SW, 9, 0, 20);
    prog[2] = ri(OP_LW, 4, 0, 20);
    prog[3] = rr(OP_ADD, 5, 4, 4);
    prog[4] = {OP_HLT, 26'd0};
    loadProg(1'b0, 5);
    doReset();
    runProgram(1'b0, "t2", cyc);
    checkOutput("t2_cycles", 32'(cyc), 32'd10);
    checkOutput("t2_retired", retired_f, 32'd5);
    readReg(1'b0, 4, rv); checkOutput("t2_r4", rv, 32'd42);
    readReg(1'b0, 5, rv); checkOutput("t2_r5", rv, 32'd84);

    $display("[TB] test 3: taken branch flush");
    prog[0] = rr(OP_ADD, 6, 0, 0);
    prog[1] = rr(OP_ADD, 7, 0, 0);
    prog[2] = ri(OP_ADDI, 1, 0, 0);
    prog[3] = ri(OP_BEQZ, 0, 1, 2);
    prog[4] = ri(OP_ADDI, 6, 0, 9);
    prog[5] = ri(OP_ADDI, 7, 0, 9);
    prog[6] = ri(OP_ADDI, 8, 0, 3);
    prog[7] = {OP_HLT, 26'd0};
    loadProg(1'b0, 8);
    doReset();
    runProgram(1'b0, "t3", cyc);
    checkOutput("t3_cycles", 32'(cyc), 32'd12);
    checkOutput("t3_retired", retired_f, 32'd6);
    readReg(1'b0, 6, rv); checkOutput("t3_r6", rv, 32'd0);
    readReg(1'b0, 7, rv); checkOutput("t3_r7", rv, 32'd0);
    readReg(1'b0, 8, rv); checkOutput("t3_r8", rv, 32'd3);

    $display("[TB] test 5: illegal opcode trap");
    prog[0] = ri(OP_ADDI, 1, 0, 1);
    prog[1] = {6'b010101, 26'd0};
    loadProg(1'b0, 2);
    doReset();
    runProgram(1'b0, "t5", cyc);
    checkOutput("t5_illegal", 32'(illegal_f), 32'd1);
    checkOutput("t5_retired", retired_f, 32'd2);
    readReg(1'b0, 1, rv); checkOutput("t5_r1", rv, 32'd1);

    $display("[TB] test 6: reset mid-run, program write while running is ignored");
    prog[0] = ri(OP_ADDI, 1, 0, 5);
    prog[1] = ri(OP_ADDI, 2, 1, 7);
    prog[2] = rr(OP_ADD, 3, 1, 2);
    prog[3] = {OP_HLT, 26'd0};
    loadProg(1'b0, 4);
    doReset();
    @(negedge clk1);
    run_f = 1'b1;
    bus_f.prog_we = 1'b1; bus_f.prog_addr = 10'd1; bus_f.prog_data = {OP_HLT, 26'd0};
    repeat (6) @(negedge clk1);
    bus_f.prog_we = 1'b0;
    checkOutput("t6_retired_midrun", retired_f, 32'd2);
    checkOutput("t6_halted_midrun", 32'(halted_f), 32'd0);
    rst_n = 1'b0;
    run_f = 1'b0;
    @(negedge clk1);
    checkOutput("t6_reset_retired", retired_f, 32'd0);
    checkOutput("t6_reset_halted", 32'(halted_f), 32'd0);
    rst_n = 1'b1;
    runProgram(1'b0, "t6", cyc);
    checkOutput("t6_cycles", 32'(cyc), 32'd8);
    checkOutput("t6_retired", retired_f, 32'd4);
    readReg(1'b0, 3, rv); checkOutput("t6_r3", rv, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
